// File: rtl/wb_port_arbiter.sv
// Writeback arbiter for the single register-file write port: ALU vs load responses,
// with a per-register pending-load scoreboard that keeps ALU writes from overtaking older loads.
module wb_port_arbiter #(
  parameter int XLEN         = 64,
  parameter int AW           = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [AW-1:0]       alu_rd,
  input  logic [XLEN-1:0]     alu_data,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [AW-1:0]       lsu_rd,
  input  logic [XLEN-1:0]     lsu_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic [(1<<AW)-1:0]  pend,
  output logic                rf_wen,
  output logic [AW-1:0]       rf_waddr,
  output logic [XLEN-1:0]     rf_wdata
);
  localparam int NREG = 1 << AW;
  localparam int CW   = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  wb_req_t         win_req;
  logic            acc;
  logic            alu_blk;
  logic            force_alu;
  logic [CW-1:0]   starve_cnt;
  logic [NREG-1:1] pend_hi;

  // x0 never has a load outstanding
  assign pend = {pend_hi, 1'b0};

  assign alu_blk   = (alu_rd != '0) && pend[alu_rd];
  assign force_alu = alu_valid && !alu_blk && (starve_cnt == CW'(STARVE_LIMIT));
  assign lsu_ready = lsu_valid && !force_alu;
  assign alu_ready = alu_valid && !alu_blk && !lsu_ready;
  assign acc       = alu_ready || lsu_ready;

  always_comb begin
    win_req = '{rd: alu_rd, data: alu_data};
    if (lsu_ready) win_req = '{rd: lsu_rd, data: lsu_data};
  end

  // A blocked ALU is waiting on ordering, not losing arbitration, so it is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve_cnt <= '0;
    else if (!alu_valid || alu_ready)
      starve_cnt <= '0;
    else if (!alu_blk && lsu_ready && (starve_cnt != CW'(STARVE_LIMIT)))
      starve_cnt <= starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= acc && (win_req.rd != '0);
      if (acc) begin
        rf_waddr <= win_req.rd;
        rf_wdata <= win_req.data;
      end
    end
  end

  for (genvar n = 1; n < NREG; n++) begin : g_pend
    wb_pend_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .set   (iss_valid && (iss_rd == AW'(n))),
      .clr   (lsu_ready && (lsu_rd == AW'(n))),
      .q     (pend_hi[n])
    );
  end
endmodule

// One scoreboard bit: a new issue beats a same-cycle writeback clear.
module wb_pend_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= 1'b0;
    else if (set) q <= 1'b1;
    else if (clr) q <= 1'b0;
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed writeback/ordering scenarios plus a random mix,
// with expected register-file writes queued at grant time and compared a cycle later.
module tb_wb_port_arbiter;
  localparam int XLEN = 64, AW = 5, LIM = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid, lsu_valid, iss_valid;
  logic            alu_ready, lsu_ready;
  logic [AW-1:0]   alu_rd, lsu_rd, iss_rd;
  logic [XLEN-1:0] alu_data, lsu_data;
  logic [31:0]     pend;
  logic            rf_wen;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  always #5 clk = ~clk;

  wb_port_arbiter #(.XLEN(XLEN), .AW(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .pend(pend),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  typedef struct {
    logic            wen;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t             exp_q[$];
  logic [31:0]     m_pend;
  int              m_cnt;
  logic [AW-1:0]   last_addr;
  logic [XLEN-1:0] last_data;
  logic            acc_alu, acc_lsu;
  int              n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are stable from posedge+1; grants are judged at negedge, the write one edge later.
  task automatic tick();
    logic blk, frc, e_lsu, e_alu;
    logic [31:0] np;
    wr_t w;
    @(negedge clk);
    blk   = alu_valid && (alu_rd != 0) && m_pend[alu_rd];
    frc   = alu_valid && !blk && (m_cnt == LIM);
    e_lsu = lsu_valid && !frc;
    e_alu = alu_valid && !blk && !e_lsu;
    chk("lsu_ready", lsu_ready, e_lsu);
    chk("alu_ready", alu_ready, e_alu);
    w.wen = 1'b0; w.addr = last_addr; w.data = last_data;
    if (e_lsu) begin
      w.wen = (lsu_rd != 0); w.addr = lsu_rd; w.data = lsu_data;
    end else if (e_alu) begin
      w.wen = (alu_rd != 0); w.addr = alu_rd; w.data = alu_data;
    end
    last_addr = w.addr; last_data = w.data;
    exp_q.push_back(w);
    if (!alu_valid || e_alu) m_cnt = 0;
    else if (!blk && e_lsu && m_cnt < LIM) m_cnt++;
    np = m_pend;
    if (e_lsu) np[lsu_rd] = 1'b0;
    if (iss_valid && iss_rd != 0) np[iss_rd] = 1'b1;
    m_pend = np;
    acc_alu = e_alu; acc_lsu = e_lsu;
    @(posedge clk); #1;
    w = exp_q.pop_front();
    chk("rf_wen", rf_wen, w.wen);
    chk("rf_waddr", rf_waddr, w.addr);
    chk("rf_wdata", rf_wdata, w.data);
    chk("pend", pend, m_pend);
  endtask

  task automatic idle();
    alu_valid = 0; lsu_valid = 0; iss_valid = 0;
  endtask

  initial begin
    rst_n = 0; idle();
    alu_rd = 0; lsu_rd = 0; iss_rd = 0; alu_data = 0; lsu_data = 0;
    m_pend = 0; m_cnt = 0; last_addr = 0; last_data = 0; acc_alu = 0; acc_lsu = 0;
    #1;
    chk("rst_wen", rf_wen, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_pend", pend, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;

    // single ALU write, then idle
    alu_valid = 1; alu_rd = 5; alu_data = 64'h1234;
    tick();
    chk("alu_w_wen", rf_wen, 1);
    chk("alu_w_addr", rf_waddr, 5);
    idle(); tick();
    chk("alu_w_idle", rf_wen, 0);

    // LSU priority, ALU forced after LIM losses
    alu_valid = 1; alu_rd = 3; alu_data = 64'hA3;
    lsu_valid = 1; lsu_rd = 7;
    for (int i = 0; i < LIM; i++) begin
      lsu_data = 64'h7000 + i;
      tick();
      chk("starve_lsu_addr", rf_waddr, 7);
    end
    lsu_data = 64'h7777;
    tick();
    chk("forced_alu_addr", rf_waddr, 3);
    alu_valid = 0; tick();
    alu_valid = 1; alu_data = 64'hB3; tick();
    chk("cnt_cleared_lsu", rf_waddr, 7);
    idle(); tick();

    // WAW ordering: ALU held behind a pending load to x9
    iss_valid = 1; iss_rd = 9; tick();
    iss_valid = 0;
    chk("pend9_set", pend[9], 1);
    alu_valid = 1; alu_rd = 9; alu_data = 64'hA9;
    repeat (3) tick();
    lsu_valid = 1; lsu_rd = 9; lsu_data = 64'hD9; tick();
    chk("load9_first", rf_wdata, 64'hD9);
    chk("pend9_clr", pend[9], 0);
    lsu_valid = 0; tick();
    chk("alu9_after", rf_wdata, 64'hA9);
    idle(); tick();

    // same-cycle set/clear of x4, then an x0 write
    iss_valid = 1; iss_rd = 4; lsu_valid = 1; lsu_rd = 4; lsu_data = 64'hD4; tick();
    chk("pend4_set_wins", pend[4], 1);
    idle();
    lsu_valid = 1; lsu_rd = 4; lsu_data = 64'hD44; tick();
    lsu_valid = 0;
    alu_valid = 1; alu_rd = 0; alu_data = 64'hFFFF; tick();
    chk("x0_no_wen", rf_wen, 0);
    idle(); tick();

    // asynchronous reset mid-cycle with a write and a pending load live
    iss_valid = 1; iss_rd = 9; tick();
    iss_valid = 0; alu_valid = 1; alu_rd = 6; alu_data = 64'h66; tick();
    chk("pre_rst_wen", rf_wen, 1);
    chk("pre_rst_pend", pend, 32'h200);
    #2 rst_n = 0;
    #1;
    chk("arst_wen", rf_wen, 0);
    chk("arst_waddr", rf_waddr, 0);
    chk("arst_wdata", rf_wdata, 0);
    chk("arst_pend", pend, 0);
    idle();
    m_pend = 0; m_cnt = 0; last_addr = 0; last_data = 0; acc_alu = 0; acc_lsu = 0;
    exp_q.delete();
    #10 rst_n = 1;
    @(posedge clk); #1;
    repeat (2) tick();

    // random mix; unaccepted requests are held stable
    for (int i = 0; i < 400; i++) begin
      if (!(alu_valid && !acc_alu)) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd = AW'($urandom_range(0, 7));
        alu_data = {$urandom, $urandom};
      end
      if (!(lsu_valid && !acc_lsu)) begin
        lsu_valid = ($urandom_range(0, 1) != 0);
        lsu_rd = AW'($urandom_range(0, 7));
        lsu_data = {$urandom, $urandom};
      end
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_rd = AW'($urandom_range(0, 7));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
